// File: rtl/uart_ram_loader_pkg.sv
// Shared definitions for the serial program loader: loader/receiver state
// encodings and the RAM write-port geometry shared with the CPU RAM/MAR.
package uart_ram_loader_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned RAM_AW    = 8;
    localparam int unsigned RAM_DW    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_WR,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic is_busy(input ld_state_t s);
        return !(s inside {ST_IDLE, ST_DONE, ST_ERR});
    endfunction

endpackage

// File: rtl/uart_ram_loader_rx.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling with a DIV
// cycle bit timer, false-start rejection and stop-bit framing check.
module uart_rx_byte
    import uart_ram_loader_pkg::*;
#(
    parameter int unsigned DIV = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // Line back high at mid start bit: treat as a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rx_s;
                    ferr_d  = !rx_s;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = shift_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_ram_loader.sv
// Serial program loader: unpacks an A5/N/words/CSUM frame from the UART and
// writes it into the CPU RAM from address 0 while holding the CPU stalled.
module uart_ram_loader
    import uart_ram_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              ram_wea,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_din,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYC);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx_byte #(.DIV(DIV)) u_rx (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .byte_valid_o(byte_valid),
        .byte_data_o (byte_data),
        .frame_err_o (frame_err)
    );

    ld_state_t         state_q, state_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [RAM_DW-1:0] din_q, din_d;
    logic              wea_q, wea_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        csum_q, csum_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;
    logic              busy_now;
    logic              timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            wea_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            csum_q  <= '0;
            idle_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wea_q   <= wea_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            csum_q  <= csum_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    assign busy_now = is_busy(state_q);
    assign timeout  = (idle_q >= TMO);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wea_d   = 1'b0;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        csum_d  = csum_q;
        done_d  = done_q;
        err_d   = err_q;
        hold_d  = hold_q;

        if (!busy_now || byte_valid) begin
            idle_d = '0;
        end else if (!timeout) begin
            idle_d = idle_q + TW'(1);
        end else begin
            idle_d = idle_q;
        end

        // An arriving byte takes priority over a timeout expiring on the same cycle.
        if (busy_now && (frame_err || (timeout && !byte_valid))) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            done_d  = 1'b0;
            hold_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (byte_valid && byte_data == SYNC_BYTE) begin
                        state_d = ST_LEN;
                        hold_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        addr_d  = '0;
                        csum_d  = '0;
                    end
                end
                ST_LEN: begin
                    if (byte_valid) begin
                        cnt_d   = (byte_data == 8'h00) ? 9'd256 : {1'b0, byte_data};
                        state_d = ST_HI;
                    end
                end
                ST_HI: begin
                    if (byte_valid) begin
                        hi_d    = byte_data;
                        csum_d  = csum_q ^ byte_data;
                        state_d = ST_LO;
                    end
                end
                ST_LO: begin
                    if (byte_valid) begin
                        csum_d  = csum_q ^ byte_data;
                        din_d   = {hi_q, byte_data};
                        wea_d   = 1'b1;
                        state_d = ST_WR;
                    end
                end
                ST_WR: begin
                    addr_d  = addr_q + 8'd1;
                    cnt_d   = cnt_q - 9'd1;
                    state_d = (cnt_q == 9'd1) ? ST_CSUM : ST_HI;
                end
                ST_CSUM: begin
                    if (byte_valid) begin
                        if (byte_data == csum_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            hold_d  = 1'b0;
                        end else begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign ram_wea  = wea_q;
    assign ram_addr = addr_q;
    assign ram_din  = din_q;
    assign cpu_hold = hold_q;
    assign busy     = busy_now;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Bench for uart_ram_loader: frames go out on the UART line, a frame-level
// model queues expected RAM writes and end-of-frame status for the monitor.
module tb_uart_ram_loader;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned DIV    = 16;
    localparam int unsigned TMO    = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        ram_wea;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        cpu_hold, busy, done, err;

    always #5 clk = ~clk;

    uart_ram_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYC(TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .ram_wea (ram_wea),
        .ram_addr(ram_addr),
        .ram_din (ram_din),
        .cpu_hold(cpu_hold),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [95:0] name;
        logic [3:0]  flags;   // {done, err, cpu_hold, busy}
        logic [7:0]  addr;
        int unsigned nwr;
        logic        chk_din;
    } stat_t;

    wr_t   exp_wr_q[$];
    stat_t exp_st_q[$];

    int          errors  = 0;
    int          checks  = 0;
    int unsigned wr_seen = 0;
    logic        prev_wea = 1'b0;

    // Frame-level reference state
    logic        m_done = 1'b0, m_err = 1'b0, m_hold = 1'b1;
    logic [7:0]  m_addr = 8'h00;
    int unsigned m_nwr  = 0;
    logic [7:0]  frm[$];

    always @(negedge clk) begin : monitor
        wr_t   e;
        stat_t s;
        if (ram_wea) begin
            wr_seen++;
            checks++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%02h din=%04h, required no write", ram_addr, ram_din);
            end else begin
                e = exp_wr_q.pop_front();
                if ({ram_addr, ram_din} != e) begin
                    errors++;
                    $display("FAIL write: got addr=%02h din=%04h, required addr=%02h din=%04h",
                             ram_addr, ram_din, e.addr, e.data);
                end
            end
            if (prev_wea) begin
                checks++;
                errors++;
                $display("FAIL wea_width: got ram_wea high 2 cycles, required 1");
            end
        end
        prev_wea = ram_wea;
        if (exp_st_q.size() > 0) begin
            s = exp_st_q.pop_front();
            checks++;
            if ({done, err, cpu_hold, busy, ram_addr} != {s.flags, s.addr}) begin
                errors++;
                $display("FAIL %0s: got done/err/hold/busy=%b addr=%02h, required %b addr=%02h",
                         s.name, {done, err, cpu_hold, busy}, ram_addr, s.flags, s.addr);
            end
            checks++;
            if (wr_seen != s.nwr) begin
                errors++;
                $display("FAIL %0s_nwr: got %0d writes, required %0d", s.name, wr_seen, s.nwr);
            end
            if (s.chk_din) begin
                checks++;
                if (ram_din != 16'h0000) begin
                    errors++;
                    $display("FAIL %0s_din: got %04h, required 0000", s.name, ram_din);
                end
            end
        end
    end

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(DIV);
        end
        rx = stop;
        cyc(12);
        rx = 1'b1;
    endtask

    task automatic push_stat(input logic [95:0] nm, input logic bsy, input logic cd);
        stat_t s;
        s.name    = nm;
        s.flags   = {m_done, m_err, m_hold, bsy};
        s.addr    = m_addr;
        s.nwr     = m_nwr;
        s.chk_din = cd;
        exp_st_q.push_back(s);
    endtask

    task automatic model_start();
        m_hold = 1'b1;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_addr = 8'h00;
    endtask

    task automatic fill_rand(input int unsigned n);
        frm.delete();
        for (int i = 0; i < 2 * n; i++) frm.push_back(8'($urandom));
    endtask

    // Sends A5, N, frm[0 .. 2N-1], CSUM; frm must hold 2N bytes.
    task automatic send_frame(input int unsigned n, input logic force_cs,
                              input logic [7:0] cs_val, input int unsigned gap_max);
        logic [7:0] x;
        logic [7:0] cs;
        x = 8'h00;
        model_start();
        for (int i = 0; i < n; i++) begin
            exp_wr_q.push_back({8'(i), frm[2*i], frm[2*i+1]});
            m_nwr++;
            x = x ^ frm[2*i] ^ frm[2*i+1];
        end
        m_addr = 8'(n);
        cs = force_cs ? cs_val : x;
        if (cs == x) begin
            m_done = 1'b1;
            m_hold = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        send_byte(8'hA5, 1'b1);
        send_byte(8'(n), 1'b1);
        for (int i = 0; i < 2 * n; i++) begin
            if (gap_max > 0) cyc($urandom_range(gap_max, 0));
            send_byte(frm[i], 1'b1);
        end
        send_byte(cs, 1'b1);
        cyc(4);
    endtask

    task automatic load_fixed(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        frm.delete();
        frm.push_back(a);
        frm.push_back(b);
        frm.push_back(c);
        frm.push_back(d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and quiet line
        rst = 1'b1;
        rx  = 1'b1;
        cyc(3);
        rst = 1'b0;
        push_stat("t1_reset", 1'b0, 1'b1);
        cyc(1000);
        push_stat("t1_idle", 1'b0, 1'b1);

        // Good two-word frame
        load_fixed(8'h12, 8'h34, 8'h56, 8'h78);
        send_frame(2, 1'b1, 8'h08, 0);
        push_stat("t2_done", 1'b0, 1'b0);

        // Bad checksum, then a good frame clears err
        send_frame(2, 1'b1, 8'h09, 0);
        push_stat("t3_csum_err", 1'b0, 1'b0);
        send_frame(2, 1'b0, 8'h00, 0);
        push_stat("t3_recover", 1'b0, 1'b0);

        // Start-bit glitch, then a framing error mid-frame
        model_start();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        rx = 1'b0;
        cyc(5);
        rx = 1'b1;
        cyc(40);
        send_byte(8'h00, 1'b0);
        cyc(4);
        m_err = 1'b1;
        push_stat("t4_ferr", 1'b0, 1'b0);

        // Reset mid-frame, then a fresh frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        model_start();
        cyc(2);
        push_stat("t6_rst", 1'b0, 1'b0);
        frm.delete();
        frm.push_back(8'hAB);
        frm.push_back(8'hCD);
        send_frame(1, 1'b1, 8'h66, 0);
        push_stat("t6_done", 1'b0, 1'b0);

        // Random frames with junk bytes and gaps
        for (int k = 0; k < 2; k++) begin
            logic [7:0]  junk;
            int unsigned n;
            junk = 8'($urandom);
            if (junk == 8'hA5) junk = 8'h5A;
            send_byte(junk, 1'b1);
            n = $urandom_range(3, 1);
            fill_rand(n);
            if ($urandom_range(3, 0) == 0)
                send_frame(n, 1'b1, 8'($urandom_range(255, 1)) ^ (frm[0] ^ frm[1]) ^ 8'h00, 20);
            else
                send_frame(n, 1'b0, 8'h00, 20);
            push_stat("rand_frame", 1'b0, 1'b0);
        end

        // Full 256-word frame, address wraps
        fill_rand(256);
        send_frame(256, 1'b0, 8'h00, 0);
        push_stat("t5_256", 1'b0, 1'b0);

        // Timeout after A5 03
        model_start();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        cyc(1900);
        push_stat("t7_waiting", 1'b1, 1'b0);
        cyc(200);
        m_err = 1'b1;
        push_stat("t7_timeout", 1'b0, 1'b0);

        cyc(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
